axis_sync_fifo_lvl: RTL and testbench

Single-clock AXI-Stream FIFO with parametrised width and depth. Adds the features the PL datapath needs beyond a plain buffer: an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and an optional drop-when-full mode with a sticky overflow flag. It sits between the PS-fed command/waveform streams and the DAC/ADC sample pipelines wherever back-pressure must be monitored rather than just absorbed.

---
 rtl/axis_sync_fifo_lvl.sv | 167 ++++++++++++++++
 tb/tb_axis_sync_fifo_lvl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sync_fifo_lvl.sv
`default_nettype none
// ============================================================================
// Module   : axis_sync_fifo_lvl
// Purpose  : Single-clock AXI-Stream FIFO with occupancy level, registered
//            almost-full / almost-empty flags, synchronous flush and an
//            optional drop-when-full mode with a sticky overflow flag.
//            Storage is a (D-1)-word RAM feeding an output register, so the
//            total capacity is D = 2**MEM_WIDTH words.
// Ports    : axis_clk, rst (sync, active-high), flush, clear_status
//            s_axis_*  : input stream (tdata/tvalid/tready)
//            m_axis_*  : output stream, tdata driven from a register
//            almost_full_thresh / almost_empty_thresh : level thresholds
//            level, almost_full, almost_empty, overflow : status outputs
// Revision : 1.0 - initial release
// ============================================================================
module axis_sync_fifo_lvl #(
  parameter int unsigned BUS_WIDTH      = 256,
  parameter int unsigned MEM_WIDTH      = 10,
  parameter bit          DROP_WHEN_FULL = 1'b0
) (
  input  logic                 axis_clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 clear_status,
  input  logic [BUS_WIDTH-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [BUS_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  input  logic [MEM_WIDTH:0]   almost_full_thresh,
  input  logic [MEM_WIDTH:0]   almost_empty_thresh,
  output logic [MEM_WIDTH:0]   level,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow
);

  localparam int unsigned          c_depth      = 2**MEM_WIDTH;
  localparam int unsigned          c_ram_words  = c_depth - 1;
  localparam logic [MEM_WIDTH:0]   c_full_level = (MEM_WIDTH+1)'(c_depth);
  localparam logic [MEM_WIDTH-1:0] c_ptr_last   = MEM_WIDTH'(c_ram_words - 1);

  // RAM pointers wrap at D-2 so all D-1 entries are used without gaps.
  function automatic logic [MEM_WIDTH-1:0] ptr_inc(input logic [MEM_WIDTH-1:0] p);
    return (p == c_ptr_last) ? '0 : p + 1'b1;
  endfunction

  logic [BUS_WIDTH-1:0] mem_q [0:c_ram_words-1];

  logic [MEM_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [MEM_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [MEM_WIDTH:0]   level_q, level_d;
  logic                 out_valid_q, out_valid_d;
  logic [BUS_WIDTH-1:0] out_data_q, out_data_d;
  logic                 overflow_q, overflow_d;
  logic                 almost_full_q, almost_full_d;
  logic                 almost_empty_q, almost_empty_d;

  logic                 w_full;
  logic                 w_wr_en;
  logic                 w_rd_en;
  logic                 w_load;
  logic [MEM_WIDTH:0]   w_ram_cnt;
  logic [BUS_WIDTH-1:0] w_ram_rdata;

  assign w_full = (level_q == c_full_level);

  // Ready depends only on registered level (and reset), never on the sink,
  // so a read from full does not open the input in the same cycle.
  generate
    if (DROP_WHEN_FULL) begin : g_drop_ready
      assign s_axis_tready = ~rst;
    end else begin : g_bp_ready
      assign s_axis_tready = ~rst & ~w_full;
    end
  endgenerate

  // In drop mode tready stays high; the ~w_full term discards the word.
  assign w_wr_en     = s_axis_tvalid & s_axis_tready & ~w_full;
  assign w_rd_en     = out_valid_q & m_axis_tready;
  // Words sitting in the RAM = total level minus the output register.
  assign w_ram_cnt   = level_q - {{MEM_WIDTH{1'b0}}, out_valid_q};
  assign w_ram_rdata = mem_q[rd_ptr_q];
  // Every word passes through the RAM for one edge before reaching the
  // output register, which gives the two-cycle tvalid-to-tvalid latency.
  assign w_load      = (w_ram_cnt != '0) & (~out_valid_q | w_rd_en);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (w_wr_en) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (w_load) begin
        rd_ptr_d    = ptr_inc(rd_ptr_q);
        out_data_d  = w_ram_rdata;
        out_valid_d = 1'b1;
      end else if (w_rd_en) begin
        out_valid_d = 1'b0;
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end

    // A set event beats a simultaneous clear.
    if (s_axis_tvalid & w_full) begin
      overflow_d = 1'b1;
    end else if (clear_status) begin
      overflow_d = 1'b0;
    end

    almost_full_d  = (level_d >= almost_full_thresh);
    almost_empty_d = (level_d <= almost_empty_thresh);
  end

  always_ff @(posedge axis_clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      overflow_q     <= 1'b0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      overflow_q     <= overflow_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!rst && !flush && w_wr_en) begin
      mem_q[wr_ptr_q] <= s_axis_tdata;
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign level         = level_q;
  assign almost_full   = almost_full_q;
  assign almost_empty  = almost_empty_q;
  assign overflow      = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_sync_fifo_lvl.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_sync_fifo_lvl
// Purpose  : Self-checking bench for axis_sync_fifo_lvl (D=16). One instance
//            in back-pressure mode, one in drop-when-full mode. Expected data
//            is queued when a write is predicted and popped on each read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_sync_fifo_lvl;

  localparam int          MW   = 4;
  localparam int          BW   = 32;
  localparam logic [MW:0] FULL = 5'd16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // back-pressure instance
  logic          rst = 1'b1, flush = 1'b0, clr = 1'b0;
  logic [BW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0, s_tready;
  logic [BW-1:0] m_tdata;
  logic          m_tvalid, m_tready = 1'b0;
  logic [MW:0]   af_th = 5'd12, ae_th = 5'd3;
  logic [MW:0]   level;
  logic          af, ae, ovf;

  // drop-when-full instance
  logic          d_flush = 1'b0, d_clr = 1'b0;
  logic [BW-1:0] d_tdata = '0;
  logic          d_tvalid = 1'b0, d_tready;
  logic [BW-1:0] d_m_tdata;
  logic          d_m_tvalid, d_m_tready = 1'b0;
  logic [MW:0]   d_level;
  logic          d_af, d_ae, d_ovf;

  axis_sync_fifo_lvl #(.BUS_WIDTH(BW), .MEM_WIDTH(MW), .DROP_WHEN_FULL(1'b0)) dut (
    .axis_clk(clk), .rst(rst), .flush(flush), .clear_status(clr),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .almost_full_thresh(af_th), .almost_empty_thresh(ae_th),
    .level(level), .almost_full(af), .almost_empty(ae), .overflow(ovf)
  );

  axis_sync_fifo_lvl #(.BUS_WIDTH(BW), .MEM_WIDTH(MW), .DROP_WHEN_FULL(1'b1)) dut_drop (
    .axis_clk(clk), .rst(rst), .flush(d_flush), .clear_status(d_clr),
    .s_axis_tdata(d_tdata), .s_axis_tvalid(d_tvalid), .s_axis_tready(d_tready),
    .m_axis_tdata(d_m_tdata), .m_axis_tvalid(d_m_tvalid), .m_axis_tready(d_m_tready),
    .almost_full_thresh(af_th), .almost_empty_thresh(ae_th),
    .level(d_level), .almost_full(d_af), .almost_empty(d_ae), .overflow(d_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the back-pressure instance.
  logic [MW:0]   mdl_lvl = '0;
  logic          mdl_tvalid = 1'b0, mdl_ovf = 1'b0, mdl_af = 1'b0, mdl_ae = 1'b1;
  logic [BW-1:0] exp_q[$];
  logic          rd_fire = 1'b0;
  logic [BW-1:0] rd_obs, rd_exp;

  // One clock of stimulus for the back-pressure instance; advances the model.
  // A word appears at the output one edge after it was accepted, so after an
  // edge tvalid is set iff a word that was stored before the edge remains.
  task automatic tick();
    logic          wr, rd, ovf_set, rst_s, flush_s, clr_s, tv_n;
    logic [MW:0]   nxt, aft, aet;
    rst_s   = rst;
    flush_s = flush;
    clr_s   = clr;
    aft     = af_th;
    aet     = ae_th;
    wr      = s_tvalid && !rst_s && (mdl_lvl != FULL);
    rd      = mdl_tvalid && m_tready;
    ovf_set = s_tvalid && (mdl_lvl == FULL);
    rd_fire = 1'b0;
    nxt     = mdl_lvl;
    tv_n    = mdl_tvalid;
    if (rst_s || flush_s) begin
      nxt  = '0;
      tv_n = 1'b0;
      exp_q.delete();
    end else begin
      if (rd) begin
        rd_fire = 1'b1;
        rd_obs  = m_tdata;
        rd_exp  = exp_q.pop_front();
      end
      if (wr) exp_q.push_back(s_tdata);
      tv_n = ((mdl_lvl - {4'b0, rd}) != 5'd0);
      nxt  = mdl_lvl + {4'b0, wr} - {4'b0, rd};
    end
    @(posedge clk);
    #1;
    mdl_lvl    = nxt;
    mdl_tvalid = tv_n;
    if (rst_s) begin
      mdl_ovf = 1'b0;
      mdl_af  = 1'b0;
      mdl_ae  = 1'b1;
    end else begin
      if (ovf_set) mdl_ovf = 1'b1;
      else if (clr_s) mdl_ovf = 1'b0;
      mdl_af = (nxt >= aft);
      mdl_ae = (nxt <= aet);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_tvalid = 1'b1; s_tdata = 32'hDEAD0001;
    d_tvalid = 1'b1; d_tdata = 32'hDEAD0002; m_tready = 1'b0;
    repeat (3) begin
      tick();
      n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready got=%b exp=0", s_tready); end
      n_checks++; if (d_tready !== 1'b0) begin n_fail++; $display("FAIL rst_drop_tready got=%b exp=0", d_tready); end
    end
    rst = 1'b0; s_tvalid = 1'b0; d_tvalid = 1'b0;
    #1;
    n_checks++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL post_rst_tready got=%b exp=1", s_tready); end
    n_checks++; if (d_tready !== 1'b1) begin n_fail++; $display("FAIL post_rst_drop_tready got=%b exp=1", d_tready); end
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid got=%b exp=0", m_tvalid); end
    n_checks++; if (m_tdata !== '0) begin n_fail++; $display("FAIL rst_tdata got=%h exp=0", m_tdata); end
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL rst_level got=%0d exp=0", level); end
    n_checks++; if (af !== 1'b0) begin n_fail++; $display("FAIL rst_af got=%b exp=0", af); end
    n_checks++; if (ae !== 1'b1) begin n_fail++; $display("FAIL rst_ae got=%b exp=1", ae); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got=%b exp=0", ovf); end
    n_checks++; if (d_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_drop_ovf got=%b exp=0", d_ovf); end
  endtask

  task automatic test_fill();
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_tdata = BW'(i);
      tick();
      n_checks++; if (level !== 5'(i)) begin n_fail++; $display("FAIL fill_level got=%0d exp=%0d", level, i); end
    end
    n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL full_tready got=%b exp=0", s_tready); end
    n_checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'h1) begin n_fail++; $display("FAIL full_head got=%b/%h exp=1/1", m_tvalid, m_tdata); end
    // read from full with a write offered: the write must not get in
    s_tdata = 32'h99; m_tready = 1'b1;
    tick();
    s_tvalid = 1'b0;
    n_checks++; if (!rd_fire || rd_obs !== rd_exp) begin n_fail++; $display("FAIL drain_data got=%h exp=%h", rd_obs, rd_exp); end
    n_checks++; if (level !== 5'd15) begin n_fail++; $display("FAIL read_from_full_level got=%0d exp=15", level); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL bp_overflow got=%b exp=1", ovf); end
    n_checks++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL ready_reassert got=%b exp=1", s_tready); end
    for (int k = 2; k <= 16; k++) begin
      n_checks++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL drain_gap got=%b exp=1 word=%0d", m_tvalid, k); end
      tick();
      n_checks++; if (!rd_fire || rd_obs !== rd_exp || rd_obs !== BW'(k)) begin n_fail++; $display("FAIL drain_data got=%h exp=%0h", rd_obs, k); end
      n_checks++; if (level !== 5'(16 - k)) begin n_fail++; $display("FAIL drain_level got=%0d exp=%0d", level, 16 - k); end
    end
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL drained_tvalid got=%b exp=0", m_tvalid); end
  endtask

  task automatic test_flush();
    m_tready = 1'b0; s_tvalid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      s_tdata = 32'h100 + BW'(i);
      tick();
    end
    n_checks++; if (level !== 5'd9) begin n_fail++; $display("FAIL preflush_level got=%0d exp=9", level); end
    flush = 1'b1; s_tdata = 32'h77; m_tready = 1'b1;
    tick();
    flush = 1'b0; s_tdata = 32'hAB;
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL flush_level got=%0d exp=0", level); end
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL flush_tvalid got=%b exp=0", m_tvalid); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL flush_ovf got=%b exp=1", ovf); end
    tick();
    s_tvalid = 1'b0;
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL latency_early got=%b exp=0", m_tvalid); end
    tick();
    n_checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'hAB) begin n_fail++; $display("FAIL post_flush_head got=%b/%h exp=1/ab", m_tvalid, m_tdata); end
    tick();
    n_checks++; if (!rd_fire || rd_obs !== rd_exp) begin n_fail++; $display("FAIL post_flush_data got=%h exp=%h", rd_obs, rd_exp); end
    n_checks++; if (level !== mdl_lvl) begin n_fail++; $display("FAIL post_flush_level got=%0d exp=%0d", level, mdl_lvl); end
  endtask

  task automatic test_clear_status();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++; if (ovf !== 1'b0 || ovf !== mdl_ovf) begin n_fail++; $display("FAIL clear_status got=%b exp=0", ovf); end
  endtask

  task automatic test_stream();
    m_tready = 1'b1; s_tvalid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      s_tdata = 32'h1000 + BW'(c);
      tick();
      n_checks++; if (m_tvalid !== (c >= 1)) begin n_fail++; $display("FAIL stream_tvalid cyc=%0d got=%b", c, m_tvalid); end
      n_checks++; if (level !== mdl_lvl || (c >= 1 && level !== 5'd2)) begin n_fail++; $display("FAIL stream_level cyc=%0d got=%0d exp=%0d", c, level, mdl_lvl); end
      if (rd_fire) begin
        n_checks++; if (rd_obs !== rd_exp) begin n_fail++; $display("FAIL stream_data got=%h exp=%h", rd_obs, rd_exp); end
      end
    end
    s_tvalid = 1'b0;
    for (int c = 0; c < 10 && mdl_lvl != 0; c++) begin
      tick();
      if (rd_fire) begin
        n_checks++; if (rd_obs !== rd_exp) begin n_fail++; $display("FAIL stream_tail got=%h exp=%h", rd_obs, rd_exp); end
      end
    end
    n_checks++; if (level !== 5'd0 || exp_q.size() != 0) begin n_fail++; $display("FAIL stream_end level=%0d left=%0d exp=0/0", level, exp_q.size()); end
  endtask

  task automatic test_thresh();
    af_th = 5'd12; ae_th = 5'd3;
    for (int c = 0; c < 420; c++) begin
      if (c < 200) begin
        s_tvalid = ($urandom_range(3) != 0); m_tready = ($urandom_range(3) == 0);
      end else if (c < 400) begin
        s_tvalid = ($urandom_range(3) == 0); m_tready = ($urandom_range(3) != 0);
      end else begin
        s_tvalid = 1'b0; m_tready = 1'b1;
      end
      if (c == 300) af_th = 5'd5;
      s_tdata = $urandom;
      tick();
      n_checks++; if (af !== mdl_af) begin n_fail++; $display("FAIL almost_full cyc=%0d got=%b exp=%b lvl=%0d", c, af, mdl_af, mdl_lvl); end
      n_checks++; if (ae !== mdl_ae) begin n_fail++; $display("FAIL almost_empty cyc=%0d got=%b exp=%b lvl=%0d", c, ae, mdl_ae, mdl_lvl); end
      n_checks++; if (level !== mdl_lvl) begin n_fail++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", c, level, mdl_lvl); end
      n_checks++; if (s_tready !== (mdl_lvl != FULL) || ovf !== mdl_ovf) begin n_fail++; $display("FAIL rand_ready_ovf got=%b/%b exp=%b/%b", s_tready, ovf, mdl_lvl != FULL, mdl_ovf); end
      if (rd_fire) begin
        n_checks++; if (rd_obs !== rd_exp) begin n_fail++; $display("FAIL rand_data got=%h exp=%h", rd_obs, rd_exp); end
      end
    end
  endtask

  task automatic test_drop();
    logic [BW-1:0] dq[$];
    logic [MW:0]   dl;
    logic [BW-1:0] obs, exp;
    dl = '0;
    d_m_tready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      d_tvalid = 1'b1; d_tdata = BW'(i);
      n_checks++; if (d_tready !== 1'b1) begin n_fail++; $display("FAIL drop_tready offer=%0d got=%b exp=1", i, d_tready); end
      if (dl != FULL) begin dq.push_back(d_tdata); dl = dl + 5'd1; end
      @(posedge clk); #1;
      n_checks++; if (d_level !== dl) begin n_fail++; $display("FAIL drop_level offer=%0d got=%0d exp=%0d", i, d_level, dl); end
      n_checks++; if (d_ovf !== (i >= 17)) begin n_fail++; $display("FAIL drop_ovf offer=%0d got=%b exp=%b", i, d_ovf, i >= 17); end
    end
    d_clr = 1'b1; d_tdata = 32'h55;
    @(posedge clk); #1;
    n_checks++; if (d_ovf !== 1'b1 || d_level !== FULL) begin n_fail++; $display("FAIL drop_set_wins got=%b/%0d exp=1/16", d_ovf, d_level); end
    d_tvalid = 1'b0;
    @(posedge clk); #1;
    d_clr = 1'b0;
    n_checks++; if (d_ovf !== 1'b0) begin n_fail++; $display("FAIL drop_clear got=%b exp=0", d_ovf); end
    d_m_tready = 1'b1;
    for (int c = 0; c < 40 && dq.size() != 0; c++) begin
      if (d_m_tvalid === 1'b1) begin
        obs = d_m_tdata; exp = dq.pop_front();
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL drop_data got=%h exp=%h", obs, exp); end
      end
      @(posedge clk); #1;
    end
    n_checks++; if (dq.size() != 0 || d_level !== 5'd0 || d_m_tvalid !== 1'b0) begin n_fail++; $display("FAIL drop_drain left=%0d level=%0d tvalid=%b exp=0/0/0", dq.size(), d_level, d_m_tvalid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_flush();
    test_clear_status();
    test_stream();
    test_thresh();
    test_drop();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
